// File: rtl/exec_sequencer.sv
// exec_sequencer: four-state instruction sequencer driving an external ALU and a 4x8 register file.
// Optional macro EXEC_SEQ_ILLEGAL_TRAP_EN makes reserved ops halt with a sticky illegal_op.
module exec_sequencer #(
    parameter logic [7:0] REG_RESET_VALUE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr_data,
    output logic [3:0]  alu_component_select,
    output logic [7:0]  alu_input_1,
    output logic [7:0]  alu_input_2,
    input  logic [7:0]  alu_output_1,
    output logic        wb_valid,
    output logic [1:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic        zero_flag,
    output logic        illegal_op,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data
);
`ifdef EXEC_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, HALT} state_t;

    state_t      state_q;
    logic [15:0] instr_q;
    logic [7:0]  regs_q [4];
    logic [7:0]  result_q;
    logic [3:0]  alu_sel_q;
    logic [7:0]  alu_in1_q;
    logic [7:0]  alu_in2_q;
    logic        wb_valid_q;
    logic [1:0]  wb_addr_q;
    logic [7:0]  wb_data_q;
    logic        zero_q;
    logic        illegal_q;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] imm;
    logic       is_ldi;
    logic       reserved;
    logic [7:0] result_d;

    assign op       = instr_q[15:12];
    assign rd       = instr_q[11:10];
    assign rs1      = instr_q[9:8];
    assign rs2      = instr_q[1:0];
    assign imm      = instr_q[7:0];
    assign is_ldi   = op == 4'b1000;
    assign reserved = !(is_ldi || op <= 4'b0100);
    assign result_d = is_ldi ? imm : alu_output_1;

    assign instr_ready          = state_q == IDLE;
    assign alu_component_select = alu_sel_q;
    assign alu_input_1          = alu_in1_q;
    assign alu_input_2          = alu_in2_q;
    assign wb_valid             = wb_valid_q;
    assign wb_addr              = wb_addr_q;
    assign wb_data              = wb_data_q;
    assign zero_flag            = zero_q;
    assign illegal_op           = illegal_q;
    assign dbg_data             = regs_q[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            result_q   <= '0;
            alu_sel_q  <= '0;
            alu_in1_q  <= '0;
            alu_in2_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= REG_RESET_VALUE;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (instr_valid) begin
                    instr_q <= instr_data;
                    state_q <= READ;
                end
                READ: begin
                    alu_sel_q <= is_ldi ? 4'b0000 : op;
                    alu_in1_q <= regs_q[rs1];
                    alu_in2_q <= regs_q[rs2];
                    illegal_q <= TRAP_EN && reserved;
                    state_q   <= (TRAP_EN && reserved) ? HALT : EXEC;
                end
                // Write-back outputs are registered here so they are visible during WB.
                EXEC: begin
                    result_q <= result_d;
                    if (!reserved) begin
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= rd;
                        wb_data_q  <= result_d;
                        zero_q     <= result_d == 8'h00;
                    end
                    state_q <= WB;
                end
                WB: begin
                    if (!reserved) regs_q[rd] <= result_q;
                    state_q <= IDLE;
                end
                default: state_q <= TRAP_EN ? HALT : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: table-driven checks of exec_sequencer with a behavioural ALU and register model.
module tb_exec_sequencer;
    localparam logic [7:0] RV = 8'h5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [3:0]  alu_component_select;
    logic [7:0]  alu_input_1;
    logic [7:0]  alu_input_2;
    logic [7:0]  alu_output_1;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        zero_flag;
    logic        illegal_op;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl [4];

    exec_sequencer #(.REG_RESET_VALUE(RV)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .alu_component_select(alu_component_select),
        .alu_input_1(alu_input_1), .alu_input_2(alu_input_2), .alu_output_1(alu_output_1),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .zero_flag(zero_flag),
        .illegal_op(illegal_op), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_output_1 = 8'h00;
        case (alu_component_select)
            4'd0: alu_output_1 = alu_input_1 + alu_input_2;
            4'd1: alu_output_1 = alu_input_1 * alu_input_2;
            4'd2: alu_output_1 = alu_input_1 & alu_input_2;
            4'd3: alu_output_1 = alu_input_1 | alu_input_2;
            4'd4: alu_output_1 = ~alu_input_1;
            default: alu_output_1 = 8'h00;
        endcase
    end

    typedef struct {
        logic [15:0] instr;
        bit          exp_wb;
        logic [7:0]  exp_data;
        bit          exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        logic [3:0] op;
        logic [1:0] rd;
        bit alu_op;
        op = v.instr[15:12];
        rd = v.instr[11:10];
        alu_op = op <= 4'd4;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = v.instr;
        for (int i = 0; i < 10 && !instr_ready; i++) @(negedge clk);
        check("ready_before_issue", {15'd0, instr_ready}, 16'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("wb_valid_k%0d_%h", k, v.instr), {15'd0, wb_valid}, {15'd0, v.exp_wb && k == 3});
            check($sformatf("ready_k%0d_%h", k, v.instr), {15'd0, instr_ready}, {15'd0, k == 4});
            if (k == 2 && (alu_op || op == 4'b1000))
                check($sformatf("alu_sel_%h", v.instr), {12'd0, alu_component_select}, {12'd0, alu_op ? op : 4'd0});
            if (k == 2 && alu_op) begin
                check($sformatf("alu_in1_%h", v.instr), {8'd0, alu_input_1}, {8'd0, mdl[v.instr[9:8]]});
                check($sformatf("alu_in2_%h", v.instr), {8'd0, alu_input_2}, {8'd0, mdl[v.instr[1:0]]});
            end
            if (k == 3) begin
                check($sformatf("zero_%h", v.instr), {15'd0, zero_flag}, {15'd0, v.exp_zero});
                if (v.exp_wb) begin
                    check($sformatf("wb_addr_%h", v.instr), {14'd0, wb_addr}, {14'd0, rd});
                    check($sformatf("wb_data_%h", v.instr), {8'd0, wb_data}, {8'd0, v.exp_data});
                end
            end
            if (k == 4) begin
                dbg_addr = rd;
                #1 check($sformatf("dbg_rd_%h", v.instr), {8'd0, dbg_data}, {8'd0, v.exp_data});
            end
        end
        if (v.exp_wb) mdl[rd] = v.exp_data;
    endtask

    initial begin
        vec_t vecs [12];
        logic [15:0] stream [4];
        int ready_cnt;
        int wb_cnt;
        int idx;
        int wb_seen;

        vecs[0]  = '{16'h8405, 1'b1, 8'h05, 1'b0};
        vecs[1]  = '{16'h8803, 1'b1, 8'h03, 1'b0};
        vecs[2]  = '{16'h0102, 1'b1, 8'h08, 1'b0};
        vecs[3]  = '{16'h8420, 1'b1, 8'h20, 1'b0};
        vecs[4]  = '{16'h8808, 1'b1, 8'h08, 1'b0};
        vecs[5]  = '{16'h1D02, 1'b1, 8'h00, 1'b1};
        vecs[6]  = '{16'h3102, 1'b1, 8'h28, 1'b0};
        vecs[7]  = '{16'h4400, 1'b1, 8'hD7, 1'b0};
        vecs[8]  = '{16'h2900, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{16'h0000, 1'b1, 8'h50, 1'b0};
        vecs[10] = '{16'hF000, 1'b0, 8'h50, 1'b0};
        vecs[11] = '{16'h8CFF, 1'b1, 8'hFF, 1'b0};
        stream[0] = 16'h8011;
        stream[1] = 16'h8422;
        stream[2] = 16'h8833;
        stream[3] = 16'h8C44;
        for (int i = 0; i < 4; i++) mdl[i] = RV;

        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr_data = '0;
        dbg_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {15'd0, instr_ready}, 16'd1);
        check("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        check("rst_wb_data", {8'd0, wb_data}, 16'd0);
        check("rst_alu_sel", {12'd0, alu_component_select}, 16'd0);
        check("rst_zero", {15'd0, zero_flag}, 16'd0);
        check("rst_illegal", {15'd0, illegal_op}, 16'd0);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = a[1:0];
            #1 check($sformatf("rst_reg%0d", a), {8'd0, dbg_data}, {8'd0, RV});
        end
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run(vecs[i]);
        check("illegal_nop_build", {15'd0, illegal_op}, 16'd0);

        // Back-to-back offers with instr_valid never dropped.
        ready_cnt = 0;
        wb_cnt = 0;
        idx = 0;
        wb_seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (wb_valid) begin
                if (wb_seen < 4) begin
                    check($sformatf("stream_wb_addr%0d", wb_seen), {14'd0, wb_addr}, {14'd0, stream[wb_seen][11:10]});
                    check($sformatf("stream_wb_data%0d", wb_seen), {8'd0, wb_data}, {8'd0, stream[wb_seen][7:0]});
                end
                wb_seen++;
                wb_cnt++;
            end
            instr_valid = idx < 4;
            instr_data  = stream[idx < 4 ? idx : 3];
            if (instr_ready) begin
                ready_cnt++;
                idx++;
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        check("stream_ready_cnt", ready_cnt[15:0], 16'd4);
        check("stream_wb_cnt", wb_cnt[15:0], 16'd4);
        dbg_addr = 2'd3;
        #1 check("stream_r3", {8'd0, dbg_data}, 16'h0044);

        // Reset asserted while add r0 is in EXEC.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data = 16'h0102;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        wb_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wb_valid) wb_cnt++;
        end
        check("midrst_no_wb", wb_cnt[15:0], 16'd0);
        check("midrst_ready", {15'd0, instr_ready}, 16'd1);
        check("midrst_wb_addr", {14'd0, wb_addr}, 16'd0);
        dbg_addr = 2'd0;
        #1 check("midrst_r0", {8'd0, dbg_data}, {8'd0, RV});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have one parameter: REG_RESET_VALUE, default 8'h00, the value loaded into every register-file entry on reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed in REQ-003 to REQ-016.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: instr_valid  input  1  an instruction is offered on instr_data.
REQ-006 Port: instr_ready  output  1  the sequencer can accept an instruction this cycle.
REQ-007 Port: instr_data  input  16  instruction: [15:12] op, [11:10] rd, [9:8] rs1, [1:0] rs2, [7:0] imm.
REQ-008 Port: alu_component_select  output  4  operation select driven to the downstream ALU.
REQ-009 Port: alu_input_1  output  8  first ALU operand.
REQ-010 Port: alu_input_2  output  8  second ALU operand.
REQ-011 Port: alu_output_1  input  8  combinational ALU result.
REQ-012 Port: wb_valid  output  1  one-cycle pulse marking a register write.
REQ-013 Port: wb_addr  output  2  index of the register written.
REQ-014 Port: wb_data  output  8  value written.
REQ-015 Port: zero_flag  output  1  set when the last written value was 8'h00.
REQ-016 Port: dbg_addr / dbg_data  input 2 / output 8  combinational read port into the register file.

Function
REQ-017 The register file SHALL be 4 x 8 bits; dbg_data SHALL equal regs[dbg_addr] and reflect a write starting the cycle after it occurs.
REQ-018 The FSM SHALL have states IDLE, READ, EXEC and WB, with only the transitions IDLE->READ (on handshake), READ->EXEC, EXEC->WB and WB->IDLE.
REQ-019 instr_ready SHALL be 1 only in IDLE; an instruction is accepted on a cycle with instr_valid && instr_ready, and instr_data is latched in that cycle.
REQ-020 In READ, the sequencer SHALL register alu_component_select = op, alu_input_1 = regs[rs1] and alu_input_2 = regs[rs2].
REQ-021 In EXEC, the sequencer SHALL capture alu_output_1 into an internal result register.
REQ-022 In WB, the sequencer SHALL write the result into regs[rd], assert wb_valid for exactly one cycle with wb_addr = rd and wb_data = the result, and update zero_flag.
REQ-023 Ops 4'b0000 to 4'b0100 (add, mult, and, or, not) SHALL go through the ALU path of REQ-020 to REQ-022.
REQ-024 Op 4'b1000 (LDI) SHALL skip the ALU: the result is imm, the same four states are traversed, and alu_component_select is 4'b0000.
REQ-025 Ops 4'b0101 to 4'b0111 and 4'b1001 to 4'b1111 are reserved and SHALL be handled per REQ-031 and REQ-032.
REQ-026 Latency: an instruction accepted at the edge ending cycle T SHALL have wb_valid high in cycle T+3, and instr_ready SHALL be high again in cycle T+4.
REQ-027 All arithmetic SHALL be 8-bit, with overflow bits discarded by the ALU; the sequencer SHALL store the value unmodified.
REQ-028 When rs1 == rd or rs2 == rd, operands SHALL be the pre-write values.
REQ-029 Outputs held outside their active state (alu_* and wb_*) SHALL retain their last value, except wb_valid, which SHALL be 0.

Reset
REQ-030 While rst_n == 0, and at any FSM state including mid-operation, the sequencer SHALL go to IDLE, load all registers with REG_RESET_VALUE, drop any in-flight instruction, and drive instr_ready = 1 after release, with wb_valid, wb_addr, wb_data, alu_component_select, alu_input_1, alu_input_2, zero_flag and illegal_op all 0.

Configuration
REQ-031 With macro EXEC_SEQ_ILLEGAL_TRAP_EN defined, a reserved op SHALL set the sticky output illegal_op (output, 1 bit) in its READ cycle, perform no write, and hold the FSM in a HALT state with instr_ready = 0 until reset.
REQ-032 Without EXEC_SEQ_ILLEGAL_TRAP_EN, a reserved op SHALL execute as a NOP: it is accepted, traverses READ, EXEC and WB with no write and wb_valid = 0, returns to IDLE, and illegal_op is tied to 0.

Verification
REQ-033 Reset release, then LDI r1,8'h05 and LDI r2,8'h03 -> wb_valid pulses with (1,05) then (2,03); dbg_data(1) = 05.
REQ-034 add r0,r1,r2 with r1=05 and r2=03 -> alu_component_select = 0, alu_input_1 = 05, alu_input_2 = 03; wb (0,08) exactly 3 cycles after acceptance; zero_flag = 0.
REQ-035 mult r3,r1,r2 with r1=8'h20 and r2=8'h08 -> wb (3,00) and zero_flag = 1.
REQ-036 instr_valid held high continuously -> instr_ready is high 1 cycle in every 4, and no instruction is lost or duplicated.
REQ-037 rst_n pulsed low during EXEC of add r0 -> no wb_valid, and r0 reads REG_RESET_VALUE.
REQ-038 Op 4'b1111 -> with EXEC_SEQ_ILLEGAL_TRAP_EN: illegal_op = 1 and instr_ready stays 0; without it: no write and instr_ready returns 4 cycles later.
